cim_tile_arbiter: RTL and testbench

//  Shares one CIM crossbar tile between NUM_REQ layer controllers (conv/flatten-FC ctrl instances).

---
 rtl/cim_tile_arbiter_pkg.sv | 15 +
 rtl/cim_tile_arbiter_if.sv | 32 +++
 rtl/cim_tile_arbiter_rr_pick.sv | 34 +++
 rtl/cim_tile_arbiter.sv | 105 ++++++++++
 tb/tb_cim_tile_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_tile_arbiter_pkg.sv
// Shared types for the CIM tile sharing logic: arbiter state encoding and
// the round-robin pointer wrap helper.
package cim_tile_arbiter_pkg;

  typedef enum logic [1:0] {
    s_cim_arb_idle  = 2'd0,
    s_cim_arb_owned = 2'd1,
    s_cim_arb_drain = 2'd2
  } t_cim_arb_state;

  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/cim_tile_arbiter_if.sv
// Bundle between NUM_REQ layer controllers, the arbiter and the CIM tile.
// The master modport is the arbiter's view; slave is the surrounding system.
interface cim_tile_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 7
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_start;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tile_we;
  logic                          tile_start;
  logic [ADDR_WIDTH-1:0]         tile_addr;
  logic                          tile_ready;
  logic [IDX_WIDTH-1:0]          owner;
  logic                          busy;

  modport master (
    input  req, req_we, req_start, req_addr, tile_ready,
    output gnt, req_ready, tile_we, tile_start, tile_addr, owner, busy
  );

  modport slave (
    output req, req_we, req_start, req_addr, tile_ready,
    input  gnt, req_ready, tile_we, tile_start, tile_addr, owner, busy
  );

endinterface

// File: rtl/cim_tile_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// Rotate so ptr lands at bit 0, priority-encode, then add ptr back.
module cim_tile_arbiter_rr_pick
  import cim_tile_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_WIDTH-1:0] enc;
  logic [IDX_WIDTH:0]   sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    valid = |rot;
    enc   = '0;
    // Descending scan so the lowest rotated position wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) enc = IDX_WIDTH'(k);
    end
    sum = {1'b0, ptr} + {1'b0, enc};
    if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
    idx = sum[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/cim_tile_arbiter.sv
// Shares one CIM crossbar tile between NUM_REQ layer controllers with
// round-robin grants held for a whole layer operation.
module cim_tile_arbiter
  import cim_tile_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 7
) (
  input logic clk,
  input logic rst,
  cim_tile_arbiter_if.master bus
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  t_cim_arb_state        state_q, state_d;
  logic [IDX_WIDTH-1:0]  owner_q, owner_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  pick_valid;
  logic [IDX_WIDTH-1:0]  pick_idx;
  logic [IDX_WIDTH-1:0]  owner_inc;
  logic                  we_mux, start_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [NUM_REQ-1:0]    ready_mux;

  cim_tile_arbiter_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign owner_inc = IDX_WIDTH'(rr_next(32'(owner_q), NUM_REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= s_cim_arb_idle;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    we_mux    = 1'b0;
    start_mux = 1'b0;
    addr_mux  = '0;
    ready_mux = '0;
    unique case (state_q)
      s_cim_arb_idle: begin
        if (pick_valid && bus.tile_ready) begin
          state_d = s_cim_arb_owned;
          owner_d = pick_idx;
        end
      end
      s_cim_arb_owned: begin
        we_mux             = bus.req_we[owner_q];
        start_mux          = bus.req_start[owner_q];
        ready_mux[owner_q] = bus.tile_ready;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (owner_q == IDX_WIDTH'(k)) addr_mux = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
        // Release: an op still running on the tile must finish before handover.
        if (!bus.req[owner_q]) begin
          if (bus.tile_ready) begin
            state_d = s_cim_arb_idle;
            ptr_d   = owner_inc;
          end else begin
            state_d = s_cim_arb_drain;
          end
        end
      end
      s_cim_arb_drain: begin
        if (bus.tile_ready) begin
          state_d = s_cim_arb_idle;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = s_cim_arb_idle;
    endcase
    if (state_d == s_cim_arb_owned) gnt_d[owner_d] = 1'b1;
  end

  assign bus.gnt        = gnt_q;
  assign bus.req_ready  = ready_mux;
  assign bus.tile_we    = we_mux;
  assign bus.tile_start = start_mux;
  assign bus.tile_addr  = addr_mux;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state_q != s_cim_arb_idle);

endmodule

// File: tb/tb_cim_tile_arbiter.sv
// Scoreboard bench for cim_tile_arbiter: a behavioural ownership model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_cim_tile_arbiter;

  localparam int N = 4;
  localparam int AW = 7;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  rdy;
    logic          we;
    logic          start;
    logic [AW-1:0] addr;
    logic [1:0]    owner;
    logic          busy;
    logic          drain;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cim_tile_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW)) bus ();

  cim_tile_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who holds the tile, whether a released op is still running,
  // where the round-robin search starts, and who held it last.
  int m_hold  = -1;
  bit m_drain = 1'b0;
  int m_ptr   = 0;
  int m_last  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    e.owner = 2'(m_last);
    e.busy  = (m_hold >= 0) || m_drain;
    e.drain = m_drain;
    if (m_hold >= 0) begin
      e.gnt[m_hold] = 1'b1;
      e.rdy[m_hold] = bus.tile_ready;
      e.we          = bus.req_we[m_hold];
      e.start       = bus.req_start[m_hold];
      e.addr        = bus.req_addr[m_hold*AW +: AW];
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_hold = -1; m_drain = 1'b0; m_ptr = 0; m_last = 0;
    end else if (m_hold >= 0) begin
      if (!bus.req[m_hold]) begin
        if (bus.tile_ready) begin
          m_ptr = (m_hold + 1) % N;
        end else begin
          m_drain = 1'b1;
        end
        m_hold = -1;
      end
    end else if (m_drain) begin
      if (bus.tile_ready) begin
        m_drain = 1'b0;
        m_ptr   = (m_last + 1) % N;
      end
    end else if (bus.tile_ready) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_hold < 0 && bus.req[c]) begin
          m_hold = c;
          m_last = c;
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(expect_now());
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    int guard;
    guard = 0;
    while (m_hold < 0 && guard < 20) begin
      step(1);
      guard++;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("gnt", 32'(bus.gnt), 32'(e.gnt));
      chk("req_ready", 32'(bus.req_ready), 32'(e.rdy));
      chk("tile_we", 32'(bus.tile_we), 32'(e.we));
      chk("tile_start", 32'(bus.tile_start), 32'(e.start));
      if (!e.drain) chk("tile_addr", 32'(bus.tile_addr), 32'(e.addr));
      chk("owner", 32'(bus.owner), 32'(e.owner));
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("start_without_gnt", 32'(bus.tile_start && (bus.gnt == '0)), 32'd0);
    end
  end

  initial begin
    rst            = 1'b1;
    bus.req        = '0;
    bus.req_we     = '0;
    bus.req_start  = '0;
    bus.req_addr   = '0;
    bus.tile_ready = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    step(1);
    rst = 1'b0;

    // Single request with address pass-through.
    bus.req_addr[0*AW +: AW] = 7'd5;
    bus.req_we = 4'b0001;
    bus.req    = 4'b0001;
    step(4);
    bus.req = '0;
    bus.req_we = '0;
    step(2);

    // Round-robin rotation with re-raising requesters.
    do_reset();
    for (int k = 0; k < N; k++) bus.req_addr[k*AW +: AW] = 7'(10 + k);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int h;
      wait_grant();
      h = (m_hold < 0) ? 0 : m_hold;
      step(3);
      bus.req[h] = 1'b0;
      step(1);
      bus.req[h] = 1'b1;
    end
    bus.req = '0;
    step(3);

    // Drain: owner 2 releases while the tile is still busy.
    do_reset();
    bus.req = 4'b0100;
    wait_grant();
    bus.req = 4'b1100;
    bus.req_start = 4'b0100;
    bus.req_we    = 4'b0100;
    step(1);
    bus.tile_ready = 1'b0;
    bus.req_start  = 4'b0000;
    step(2);
    bus.req       = 4'b1000;
    bus.req_start = 4'b1100;
    step(10);
    bus.tile_ready = 1'b1;
    step(4);
    bus.req = '0;
    bus.req_start = '0;
    bus.req_we = '0;
    step(2);

    // Tile busy while idle: no grant until ready returns.
    do_reset();
    bus.tile_ready = 1'b0;
    bus.req = 4'b0100;
    step(5);
    bus.tile_ready = 1'b1;
    step(3);
    bus.req = '0;
    step(2);

    // Isolation: non-owner 1 toggles start while 0 owns.
    do_reset();
    bus.req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      bus.req_start = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      bus.req_we    = 4'b0010;
      step(1);
    end
    bus.req = '0;
    bus.req_start = '0;
    bus.req_we = '0;
    step(2);

    // Reset while owner 3 holds the tile, then pointer restarts at 0.
    do_reset();
    bus.req = 4'b1000;
    wait_grant();
    bus.req_start = 4'b1000;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.req_start = '0;
    bus.req = 4'b1001;
    step(4);
    bus.req = '0;
    step(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.req_we     = 4'($urandom);
      bus.req_start  = 4'($urandom);
      bus.req_addr   = 28'($urandom);
      bus.tile_ready = ($urandom_range(0, 4) != 0);
      rst            = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;
    step(1);

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
